// File: rtl/hwpe_ctrl_periph_arb_pkg.sv
// Shared types and defaults for the peripheral arbiter that fronts the HWPE control slave.
// periph_req_t describes one core request in the default 32-bit geometry.
package hwpe_ctrl_package;

   localparam int unsigned PERIPH_ARB_MAX_OUTSTANDING = 2;
   localparam int unsigned PERIPH_ADDR_WIDTH          = 32;
   localparam int unsigned PERIPH_DATA_WIDTH          = 32;

   typedef struct packed {
      logic [PERIPH_ADDR_WIDTH-1:0]   add;
      logic                           wen;
      logic [PERIPH_DATA_WIDTH/8-1:0] be;
      logic [PERIPH_DATA_WIDTH-1:0]   data;
   } periph_req_t;

endpackage

// File: rtl/hwpe_ctrl_periph_arb_slice.sv
// One-entry request register slice between the arbiter and the control slave port.
// Accepts a new entry when empty or when the held entry drains in the same cycle.
module hwpe_ctrl_periph_arb_slice
   import hwpe_ctrl_package::*;
#(
   parameter type         req_t    = periph_req_t,
   parameter int unsigned ID_WIDTH = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                push_valid,
   output logic                push_ready,
   input  req_t                push_req,
   input  logic [ID_WIDTH-1:0] push_id,
   output logic                pop_valid,
   input  logic                pop_ready,
   output req_t                pop_req,
   output logic [ID_WIDTH-1:0] pop_id
);

   logic                valid_q;
   req_t                req_q;
   logic [ID_WIDTH-1:0] id_q;

   assign push_ready = ~valid_q | pop_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         req_q   <= '0;
         id_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (push_ready) begin
         valid_q <= push_valid;
         if (push_valid) begin
            req_q <= push_req;
            id_q  <= push_id;
         end
      end
   end

   // Payload reads as zero whenever the slice is empty.
   assign pop_valid = valid_q;
   assign pop_req   = valid_q ? req_q : '0;
   assign pop_id    = valid_q ? id_q : '0;

endmodule

// File: rtl/hwpe_ctrl_periph_arb.sv
// Round-robin arbiter of N_CORES peripheral ports onto the HWPE control slave, with an
// outstanding-response limit. Define HWPE_CTRL_PERIPH_ARB_REQ_REG_EN for a registered request path.
module hwpe_ctrl_periph_arb
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned N_CORES         = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ID_WIDTH        = 16,
   parameter int unsigned MAX_OUTSTANDING = PERIPH_ARB_MAX_OUTSTANDING
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic [N_CORES-1:0]      req_i,
   input  logic [ADDR_WIDTH-1:0]   add_i  [N_CORES],
   input  logic [N_CORES-1:0]      wen_i,
   input  logic [DATA_WIDTH/8-1:0] be_i   [N_CORES],
   input  logic [DATA_WIDTH-1:0]   data_i [N_CORES],
   output logic [N_CORES-1:0]      gnt_o,
   output logic [N_CORES-1:0]      r_valid_o,
   output logic [DATA_WIDTH-1:0]   r_data_o [N_CORES],
   output logic                    cfg_req_o,
   output logic [ADDR_WIDTH-1:0]   cfg_add_o,
   output logic                    cfg_wen_o,
   output logic [DATA_WIDTH/8-1:0] cfg_be_o,
   output logic [DATA_WIDTH-1:0]   cfg_data_o,
   output logic [ID_WIDTH-1:0]     cfg_id_o,
   input  logic                    cfg_gnt_i,
   input  logic                    cfg_r_valid_i,
   input  logic [DATA_WIDTH-1:0]   cfg_r_data_i,
   input  logic [ID_WIDTH-1:0]     cfg_r_id_i
);

   localparam int unsigned RR_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   // Same layout as periph_req_t, sized by this instance's parameters.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   add;
      logic                    wen;
      logic [DATA_WIDTH/8-1:0] be;
      logic [DATA_WIDTH-1:0]   data;
   } arb_req_t;

   logic [RR_W-1:0]     rr_q, rr_d, win, idx;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                any_req, stall, arb_req, arb_ready, up_hs;
   arb_req_t            req_w;
   logic [ID_WIDTH-1:0] id_w;

   // Scan from the highest offset down so the core nearest rr_q wins.
   always_comb begin : rr_search
      win     = '0;
      idx     = '0;
      any_req = 1'b0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         idx = RR_W'((int'(rr_q) + k) % N_CORES);
         if (req_i[idx]) begin
            win     = idx;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin : winner_payload
      req_w.add  = add_i[win];
      req_w.wen  = wen_i[win];
      req_w.be   = be_i[win];
      req_w.data = data_i[win];
      id_w       = '0;
      for (int i = 0; i < N_CORES; i++) id_w[i] = (win == RR_W'(i));
   end

   // A response in the same cycle frees a slot, so it lifts the stall.
   assign stall   = (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~cfg_r_valid_i;
   assign arb_req = any_req & ~stall & ~clear_i & rst_ni;
   assign up_hs   = arb_req & arb_ready;

   always_comb begin : grant_decode
      gnt_o = '0;
      for (int i = 0; i < N_CORES; i++) gnt_o[i] = up_hs & (win == RR_W'(i));
   end

   always_comb begin : state_next
      rr_d  = rr_q;
      cnt_d = cnt_q;
      if (up_hs) rr_d = (win == RR_W'(N_CORES - 1)) ? '0 : win + 1'b1;
      if (up_hs && !cfg_r_valid_i)                      cnt_d = cnt_q + 1'b1;
      else if (!up_hs && cfg_r_valid_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rr_q  <= clear_i ? '0 : rr_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin : rsp_valid
      r_valid_o = '0;
      for (int i = 0; i < N_CORES; i++) r_valid_o[i] = rst_ni & cfg_r_valid_i & cfg_r_id_i[i];
   end

   for (genvar i = 0; i < N_CORES; i++) begin : g_rsp_data
      assign r_data_o[i] = rst_ni ? cfg_r_data_i : '0;
   end

   if (ID_WIDTH > N_CORES) begin : g_unused_id
      logic unused_id;
      assign unused_id = ^cfg_r_id_i[ID_WIDTH-1:N_CORES];
   end

`ifdef HWPE_CTRL_PERIPH_ARB_REQ_REG_EN
   arb_req_t            slice_req;
   logic [ID_WIDTH-1:0] slice_id;
   logic                slice_valid;

   hwpe_ctrl_periph_arb_slice #(
      .req_t    (arb_req_t),
      .ID_WIDTH (ID_WIDTH)
   ) i_slice (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .push_valid (arb_req),
      .push_ready (arb_ready),
      .push_req   (req_w),
      .push_id    (id_w),
      .pop_valid  (slice_valid),
      .pop_ready  (cfg_gnt_i),
      .pop_req    (slice_req),
      .pop_id     (slice_id)
   );

   assign cfg_req_o  = slice_valid;
   assign cfg_add_o  = slice_req.add;
   assign cfg_wen_o  = slice_req.wen;
   assign cfg_be_o   = slice_req.be;
   assign cfg_data_o = slice_req.data;
   assign cfg_id_o   = slice_id;
`else
   assign arb_ready  = cfg_gnt_i;
   assign cfg_req_o  = arb_req;
   assign cfg_add_o  = arb_req ? req_w.add  : '0;
   assign cfg_wen_o  = arb_req ? req_w.wen  : 1'b0;
   assign cfg_be_o   = arb_req ? req_w.be   : '0;
   assign cfg_data_o = arb_req ? req_w.data : '0;
   assign cfg_id_o   = arb_req ? id_w       : '0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_periph_arb.sv
// Bench for hwpe_ctrl_periph_arb: directed scenarios plus random traffic checked against a
// queue-based reference model, with a separate monitor draining the expected queues.
`timescale 1ns/1ps
module tb_hwpe_ctrl_periph_arb;

   localparam int N    = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int IW   = 16;
   localparam int MAXO = 2;
   localparam int GW   = 1 + N + IW + AW + DW + 1 + DW/8;
   localparam int RW   = N + N*DW;

   // clock / reset
   logic clk_i   = 1'b0;
   logic rst_ni  = 1'b0;
   logic clear_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [N-1:0]      req_i = '0;
   logic [N-1:0]      wen_i = '0;
   logic [AW-1:0]     add_i  [N];
   logic [DW/8-1:0]   be_i   [N];
   logic [DW-1:0]     data_i [N];
   logic [N-1:0]      gnt_o, r_valid_o;
   logic [DW-1:0]     r_data_o [N];
   logic              cfg_req_o, cfg_wen_o;
   logic [AW-1:0]     cfg_add_o;
   logic [DW/8-1:0]   cfg_be_o;
   logic [DW-1:0]     cfg_data_o;
   logic [IW-1:0]     cfg_id_o;
   logic              cfg_gnt_i     = 1'b0;
   logic              cfg_r_valid_i = 1'b0;
   logic [DW-1:0]     cfg_r_data_i  = '0;
   logic [IW-1:0]     cfg_r_id_i    = '0;

   hwpe_ctrl_periph_arb #(
      .N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i),
      .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
      .cfg_req_o(cfg_req_o), .cfg_add_o(cfg_add_o), .cfg_wen_o(cfg_wen_o), .cfg_be_o(cfg_be_o),
      .cfg_data_o(cfg_data_o), .cfg_id_o(cfg_id_o),
      .cfg_gnt_i(cfg_gnt_i), .cfg_r_valid_i(cfg_r_valid_i), .cfg_r_data_i(cfg_r_data_i),
      .cfg_r_id_i(cfg_r_id_i)
   );

   // scoreboard
   int checks   = 0;
   int failures = 0;
   logic [GW-1:0] gnt_q [$];
   logic [RW-1:0] rsp_q [$];
   int ptr = 0;
   int cnt = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: nearest requester at or after ptr wins; at most MAXO unanswered grants.
   task automatic model_step();
      int            w;
      int            best;
      logic          hs;
      logic [N-1:0]  gv;
      logic [IW-1:0] idv;
      logic [N-1:0]  rv_vec;
      if (!rst_ni) begin
         ptr = 0;
         cnt = 0;
         return;
      end
      w    = -1;
      best = N;
      for (int i = 0; i < N; i++)
         if (req_i[i] && ((i - ptr + N) % N) < best) begin
            best = (i - ptr + N) % N;
            w    = i;
         end
      hs = (w >= 0) && !clear_i && !(cnt == MAXO && !cfg_r_valid_i) && cfg_gnt_i;
      if (hs) begin
         gv     = '0;
         gv[w]  = 1'b1;
         idv    = '0;
         idv[w] = 1'b1;
         gnt_q.push_back({1'b1, gv, idv, add_i[w], data_i[w], wen_i[w], be_i[w]});
      end
      rv_vec = cfg_r_valid_i ? cfg_r_id_i[N-1:0] : '0;
      if (rv_vec != '0) rsp_q.push_back({rv_vec, {N{cfg_r_data_i}}});
      if (clear_i) ptr = 0;
      else if (hs) ptr = (w + 1) % N;
      if (hs && !cfg_r_valid_i) cnt++;
      else if (!hs && cfg_r_valid_i && cnt > 0) cnt--;
   endtask

   // driver tasks
   task automatic drive_full(input logic rst, input logic [N-1:0] req, input logic gnt,
                             input logic rv, input logic [IW-1:0] rid, input logic clr,
                             input int fix_core, input logic [AW-1:0] fix_add,
                             input logic [DW-1:0] fix_data, input logic fix_wen);
      @(negedge clk_i);
      rst_ni        = rst;
      req_i         = req;
      cfg_gnt_i     = gnt;
      cfg_r_valid_i = rv;
      cfg_r_id_i    = rid;
      clear_i       = clr;
      cfg_r_data_i  = $urandom;
      for (int i = 0; i < N; i++) begin
         add_i[i]  = $urandom;
         data_i[i] = $urandom;
         wen_i[i]  = 1'($urandom_range(0, 1));
         be_i[i]   = 4'($urandom_range(0, 15));
      end
      if (fix_core >= 0) begin
         add_i[fix_core]  = fix_add;
         data_i[fix_core] = fix_data;
         wen_i[fix_core]  = fix_wen;
      end
      model_step();
   endtask

   task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                        input logic [IW-1:0] rid, input logic clr);
      drive_full(1'b1, req, gnt, rv, rid, clr, -1, '0, '0, 1'b0);
   endtask

`ifndef HWPE_CTRL_PERIPH_ARB_REQ_REG_EN
   initial begin : monitor
      logic [GW-1:0] act_g, exp_g;
      logic [RW-1:0] act_r, exp_r;
      forever begin
         @(negedge clk_i);
         #2;
         if ((|gnt_o) || (cfg_req_o && cfg_gnt_i)) begin
            act_g = {cfg_req_o, gnt_o, cfg_id_o, cfg_add_o, cfg_data_o, cfg_wen_o, cfg_be_o};
            if (gnt_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL gnt_unexpected actual=%0h required=none", act_g);
            end else begin
               exp_g = gnt_q.pop_front();
               check("gnt_txn", act_g, exp_g);
            end
         end
         if (|r_valid_o) begin
            act_r = {r_valid_o, r_data_o[0], r_data_o[1], r_data_o[2], r_data_o[3]};
            if (rsp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected actual=%0h required=none", act_r);
            end else begin
               exp_r = rsp_q.pop_front();
               check("rsp_txn", act_r, exp_r);
            end
         end
      end
   end
`endif

   logic [IW-1:0] rr_id_tab [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0001};

   initial begin : main
      for (int i = 0; i < N; i++) begin
         add_i[i]  = '0;
         be_i[i]   = '0;
         data_i[i] = '0;
      end
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_cfg_req", cfg_req_o, 0);
      check("rst_gnt", gnt_o, 0);
      check("rst_rvalid", r_valid_o, 0);
      check("rst_cfg_id", cfg_id_o, 0);
      check("rst_cfg_add", cfg_add_o, 0);
      check("rst_cfg_data", cfg_data_o, 0);
      check("rst_cfg_be", cfg_be_o, 0);
      @(negedge clk_i);
      req_i = '1; cfg_gnt_i = 1'b1; cfg_r_valid_i = 1'b1; cfg_r_id_i = 16'h0001;
      #1;
      check("rst_busy_cfg_req", cfg_req_o, 0);
      check("rst_busy_gnt", gnt_o, 0);
      check("rst_busy_rvalid", r_valid_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1; req_i = '0; cfg_gnt_i = 1'b0; cfg_r_valid_i = 1'b0; cfg_r_id_i = '0;

`ifdef HWPE_CTRL_PERIPH_ARB_REQ_REG_EN
      @(negedge clk_i);
      req_i = 4'b0010; wen_i[1] = 1'b0; data_i[1] = 32'hDEADBEEF; add_i[1] = 32'h4; cfg_gnt_i = 1'b1;
      #1;
      check("slice_gnt", gnt_o, 4'b0010);
      check("slice_not_yet", cfg_req_o, 0);
      @(negedge clk_i);
      req_i = '0;
      #1;
      check("slice_cfg_req", cfg_req_o, 1);
      check("slice_cfg_data", cfg_data_o, 32'hDEADBEEF);
      check("slice_cfg_id", cfg_id_o, 16'h0002);
      check("slice_cfg_add", cfg_add_o, 32'h4);
      check("slice_cfg_wen", cfg_wen_o, 0);
      @(negedge clk_i);
      #1;
      check("slice_drained", cfg_req_o, 0);
`else
      // round robin over all four cores
      for (int k = 0; k < 5; k++) begin
         drive(4'hF, 1'b1, 1'b1, 16'(1 << $urandom_range(0, N-1)), 1'b0);
         #1;
         check("rr_gnt", gnt_o, rr_id_tab[k][N-1:0]);
         check("rr_cfg_id", cfg_id_o, rr_id_tab[k]);
      end
      // core 2 read and its response
      drive_full(1'b1, 4'b0100, 1'b1, 1'b0, '0, 1'b0, 2, 32'h0000_000C, $urandom, 1'b1);
      #1;
      check("rd_gnt", gnt_o, 4'b0100);
      check("rd_cfg_add", cfg_add_o, 32'h0000_000C);
      check("rd_cfg_wen", cfg_wen_o, 1);
      drive(4'h0, 1'b0, 1'b1, 16'h0004, 1'b0);
      #1;
      check("rd_rvalid", r_valid_o, 4'b0100);
      check("rd_rdata", r_data_o[2], cfg_r_data_i);
      // clear with the pointer sitting on core 3 and one response outstanding
      drive(4'b0100, 1'b1, 1'b0, '0, 1'b0);
      drive(4'hF, 1'b1, 1'b0, '0, 1'b1);
      #1;
      check("clr_no_gnt", gnt_o, 0);
      drive(4'hF, 1'b1, 1'b0, '0, 1'b0);
      #1;
      check("clr_winner", gnt_o, 4'b0001);
      drive(4'hF, 1'b1, 1'b0, '0, 1'b0);
      #1;
      check("clr_cnt_kept", gnt_o, 0);
      drive(4'h0, 1'b0, 1'b1, 16'h0004, 1'b0);
      drive(4'h0, 1'b0, 1'b1, 16'h0001, 1'b0);
      // outstanding limit
      for (int k = 0; k < 6; k++) begin
         drive(4'hF, 1'b1, 1'b0, '0, 1'b0);
         #1;
         if (k >= MAXO) check("stall_gnt", gnt_o, 0);
         else check("pre_stall_gnt", |gnt_o, 1);
      end
      drive(4'hF, 1'b1, 1'b1, 16'h0002, 1'b0);
      #1;
      check("resume_gnt", |gnt_o, 1);
      drive(4'hF, 1'b1, 1'b0, '0, 1'b0);
      #1;
      check("restall_gnt", gnt_o, 0);
      drive(4'h0, 1'b0, 1'b1, 16'h0001, 1'b0);
      drive(4'h0, 1'b0, 1'b1, 16'h0002, 1'b0);
      // random traffic
      repeat (400)
         drive(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               16'(1 << $urandom_range(0, N-1)), $urandom_range(0, 31) == 0);
      repeat (4) drive(4'h0, 1'b0, 1'b1, 16'h0008, 1'b0);
      // reset while a response is outstanding
      drive(4'b0001, 1'b1, 1'b0, '0, 1'b0);
      drive_full(1'b0, 4'hF, 1'b1, 1'b1, 16'h0001, 1'b0, -1, '0, '0, 1'b0);
      #1;
      check("midrst_cfg_req", cfg_req_o, 0);
      check("midrst_gnt", gnt_o, 0);
      check("midrst_rvalid", r_valid_o, 0);
      check("midrst_cfg_id", cfg_id_o, 0);
      check("midrst_rdata", r_data_o[0], 0);
      drive(4'h0, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(4'hF, 1'b1, 1'b0, '0, 1'b0);
         #1;
         if (k == 1) check("postrst_second_gnt", |gnt_o, 1);
      end
      drive(4'h0, 1'b0, 1'b1, 16'h0001, 1'b0);
      drive(4'h0, 1'b0, 1'b1, 16'h0002, 1'b0);
      repeat (2) drive(4'h0, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk_i);
      #3;
      check("gnt_q_empty", gnt_q.size(), 0);
      check("rsp_q_empty", rsp_q.size(), 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hwpe_ctrl_periph_arb.md
HWPE_CTRL_PERIPH_ARB -- requirements
Module: hwpe_ctrl_periph_arb

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of requesting cores.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 16, ID_WIDTH >= N_CORES: one-hot core id width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 2: responses in flight before grants stall.
REQ-006 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-009 SHALL have per-core ports req_i, add_i, wen_i (1 = read), be_i and data_i, inputs, each [N_CORES] wide: core requests.
REQ-010 SHALL have per-core ports gnt_o, r_valid_o and r_data_o, outputs, each [N_CORES] wide: core grant and response.
REQ-011 SHALL have downstream ports cfg_req_o, cfg_add_o, cfg_wen_o, cfg_be_o, cfg_data_o and cfg_id_o[ID_WIDTH], outputs: feed the control slave.
REQ-012 SHALL have downstream ports cfg_gnt_i, cfg_r_valid_i, cfg_r_data_i and cfg_r_id_i[ID_WIDTH], inputs: control slave response.

Function
REQ-013 SHALL pick one winner among asserted req_i each cycle by round-robin, starting the search at pointer rr_q.
REQ-014 SHALL drive cfg_id_o one-hot with bit w set for winner w and all other bits zero.
REQ-015 SHALL, without the register slice, drive cfg_* combinationally from the winner and assert gnt_o[w] = cfg_gnt_i & cfg_req_o, with zero-cycle latency.
REQ-016 SHALL, on handshake (cfg_req_o & cfg_gnt_i), update rr_q to (w+1) mod N_CORES; otherwise hold rr_q.
REQ-017 SHALL track outstanding responses in a counter: +1 on handshake, -1 on cfg_r_valid_i, unchanged on both or neither.
REQ-018 SHALL, when the counter equals MAX_OUTSTANDING and no cfg_r_valid_i occurs that cycle, deassert cfg_req_o and all gnt_o.
REQ-019 SHALL hold the counter at 0 if cfg_r_valid_i arrives while it is 0, with no underflow.
REQ-020 SHALL assert r_valid_o[i] = cfg_r_valid_i & cfg_r_id_i[i] and broadcast cfg_r_data_i to every r_data_o.
REQ-021 SHALL treat reads and writes identically; every accepted request yields exactly one response.
REQ-022 SHALL hold all gnt_o low and cfg_req_o low when no req_i is asserted.
REQ-023 SHALL, on clear_i, reset rr_q to 0 and empty the register slice, leave the counter untouched, and grant nothing that cycle.

Reset
REQ-024 SHALL reset rr_q to 0 and the counter to 0.
REQ-025 SHALL reset cfg_req_o, all gnt_o and all r_valid_o to 0, and reset cfg_id_o, cfg_add_o, cfg_data_o and cfg_be_o to 0.
REQ-026 SHALL, on reset mid-transaction, discard any in-flight request and response.

Configuration
REQ-027 SHALL compile a one-entry request register slice between the arbiter and the cfg_* ports when macro HWPE_CTRL_PERIPH_ARB_REQ_REG_EN is defined.
REQ-028 SHALL, with the slice, grant a core when the slice is empty or drains that cycle (cfg_gnt_i), present the slice content on cfg_* one cycle after grant, and count the slice entry as outstanding.
REQ-029 SHALL, without the macro, contain no slice and follow REQ-015.

Structure
REQ-030 SHALL place in hwpe_ctrl_package: a typedef for the per-core request struct (add, wen, be, data) and the default MAX_OUTSTANDING constant.
REQ-031 SHALL implement the register slice as sub-module hwpe_ctrl_periph_arb_slice, instantiated only under the macro.

Verification
REQ-032 SHALL cover, after reset, req_i=4'b1111 held with cfg_gnt_i=1 -> grants to cores 0,1,2,3,0 on consecutive cycles, with cfg_id_o 0x0001,0x0002,0x0004,0x0008,0x0001.
REQ-033 SHALL cover core 2 alone reading addr 0x0C with cfg_r_valid_i=1 and cfg_r_id_i=0x0004 the next cycle -> r_valid_o=4'b0100 and r_data_o[2] equals cfg_r_data_i.
REQ-034 SHALL cover cfg_r_valid_i held 0 with continuous requests -> exactly 2 handshakes, then gnt_o=0 until a response arrives, then 1 further grant.
REQ-035 SHALL cover clear_i pulsed while rr_q=3 -> next winner with req_i=4'b1111 is core 0 and the counter is unchanged.
REQ-036 SHALL cover, with HWPE_CTRL_PERIPH_ARB_REQ_REG_EN, core 1 write of data 0xDEADBEEF -> cfg_req_o one cycle after gnt_o[1], carrying 0xDEADBEEF and cfg_id_o=0x0002.
REQ-037 SHALL cover rst_ni dropped with counter=1 -> all outputs 0 immediately, and the counter is 0 after release.
